// File: rtl/router_pkg.sv
// Shared types and constants for the router packet generator: field widths,
// FSM state encoding and the payload LFSR polynomial.
package router_pkg;

  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam logic [ADDR_W-1:0] MAX_ADDR = 2'd2;

  // Bit i set means state bit i feeds the XOR (x^8+x^6+x^5+x^4+1).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY
  } state_e;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/router_lfsr8.sv
// 8-bit Fibonacci LFSR, shifting left; steps only when adv is high and
// returns to SEED only on reset.
module router_lfsr8
  import router_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  output logic [7:0] q
);

  logic [7:0] q_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else if (adv) begin
      q_q <= lfsr_next(q_q);
    end
  end

  assign q = q_q;

endmodule

// File: rtl/router_pkt_gen.sv
// Router packet source: emits header, LFSR payload and even-parity byte for
// each accepted start request, holding the current byte while busy is high.
module router_pkt_gen
  import router_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              busy,
  output logic [7:0]        datain,
  output logic              packet_valid,
  output logic              ready,
  output logic              done,
  output logic              rej
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       par_q, par_d;
  logic [7:0]       data_q, data_d;
  logic             pv_q, pv_d;
  logic             done_q, done_d;
  logic             rej_q, rej_d;
  logic             lfsr_adv;
  logic [7:0]       lfsr_q;
  logic             accept;

  router_lfsr8 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .adv   (lfsr_adv),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      par_q   <= '0;
      data_q  <= '0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      data_q  <= data_d;
      pv_q    <= pv_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
    end
  end

  assign accept = (state_q != ST_IDLE) && !busy;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    data_d   = data_q;
    pv_d     = pv_q;
    done_d   = 1'b0;
    rej_d    = 1'b0;
    lfsr_adv = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if ((addr <= MAX_ADDR) && (len != '0)) begin
            state_d = ST_HEADER;
            len_d   = len;
            cnt_d   = '0;
            data_d  = {len, addr};
            par_d   = {len, addr};
            pv_d    = 1'b1;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      ST_HEADER: begin
        if (accept) begin
          state_d = ST_PAYLOAD;
          data_d  = lfsr_q;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          lfsr_adv = 1'b1;
          par_d    = par_q ^ data_q;
          cnt_d    = cnt_q + LEN_W'(1);
          // The byte on the bus is the last one: present the folded parity next.
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_PARITY;
            data_d  = par_q ^ data_q;
            pv_d    = 1'b0;
          end else begin
            data_d = lfsr_next(lfsr_q);
          end
        end
      end
      ST_PARITY: begin
        if (accept) begin
          state_d = ST_IDLE;
          data_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign datain       = data_q;
  assign packet_valid = pv_q;
  assign ready        = (state_q == ST_IDLE);
  assign done         = done_q;
  assign rej          = rej_q;

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: a byte-stream reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_router_pkt_gen;

  logic       clk;
  logic       reset;
  logic       start;
  logic [1:0] addr;
  logic [5:0] len;
  logic       busy;
  logic [7:0] datain;
  logic       packet_valid;
  logic       ready;
  logic       done;
  logic       rej;

  router_pkt_gen #(.SEED(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .addr         (addr),
    .len          (len),
    .busy         (busy),
    .datain       (datain),
    .packet_valid (packet_valid),
    .ready        (ready),
    .done         (done),
    .rej          (rej)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] data;
    logic       pv;
  } exp_byte_t;

  exp_byte_t  exp_q[$];
  logic [7:0] m_lfsr;
  logic       exp_done;
  logic       exp_rej;

  // Polynomial exponents x^8, x^6, x^5, x^4 select state bits 7, 5, 4, 3.
  function automatic logic [7:0] model_step(input logic [7:0] s);
    int taps[4] = '{8, 6, 5, 4};
    logic fb = 1'b0;
    foreach (taps[i]) fb = fb ^ s[taps[i]-1];
    return {s[6:0], fb};
  endfunction

  function automatic void build_packet(input logic [1:0] a, input logic [5:0] l,
                                       input logic [7:0] seed, output logic [7:0] seed_after);
    logic [7:0] hdr = {l, a};
    logic [7:0] par = hdr;
    logic [7:0] s   = seed;
    exp_q.push_back('{data: hdr, pv: 1'b1});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back('{data: s, pv: 1'b1});
      par = par ^ s;
      s   = model_step(s);
    end
    exp_q.push_back('{data: par, pv: 1'b0});
    seed_after = s;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      m_lfsr   <= 8'hA5;
      exp_done <= 1'b0;
      exp_rej  <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      exp_rej  <= 1'b0;
      if (exp_q.size() == 0) begin
        if (start) begin
          if (addr == 2'd3 || len == 6'd0) begin
            exp_rej <= 1'b1;
          end else begin
            logic [7:0] nxt;
            build_packet(addr, len, m_lfsr, nxt);
            m_lfsr <= nxt;
          end
        end
      end else if (!busy) begin
        if (exp_q.size() == 1) exp_done <= 1'b1;
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (exp_q.size() != 0) begin
        check("datain", 32'(datain), 32'(exp_q[0].data));
        check("packet_valid", 32'(packet_valid), 32'(exp_q[0].pv));
        check("ready_busy", 32'(ready), 32'(0));
      end else begin
        check("idle_pv", 32'(packet_valid), 32'(0));
        check("idle_ready", 32'(ready), 32'(1));
      end
      check("done", 32'(done), 32'(exp_done));
      check("rej", 32'(rej), 32'(exp_rej));
    end
  end

  int rej_cnt  = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (!reset && rej)  rej_cnt  <= rej_cnt + 1;
    if (!reset && done) done_cnt <= done_cnt + 1;
  end

  // ---------------- stimulus ----------------
  logic [7:0] obs_d[4];
  logic       obs_pv[4];

  task automatic run_packet(input logic [1:0] a, input logic [5:0] l,
                            input int stall_at, input int stall_n, input int inject_at,
                            output int nbytes, output logic [7:0] par);
    int cycles;
    par   = 8'h00;
    addr  = a;
    len   = l;
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    addr   = 2'($urandom_range(0, 3));
    len    = 6'($urandom_range(0, 63));
    cycles = 1;
    while (!done && cycles < 300) begin
      if (cycles <= 4) begin
        obs_d[cycles-1]  = datain;
        obs_pv[cycles-1] = packet_valid;
      end
      if (!packet_valid && !ready) par = datain;
      if (cycles == stall_at) busy = 1'b1;
      if (cycles == stall_at + stall_n) busy = 1'b0;
      if (cycles == inject_at) begin
        start = 1'b1;
        addr  = 2'd2;
        len   = 6'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    busy  = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL pkt_timeout: no done within %0d cycles", cycles);
    end
    check("gap_pv", 32'(packet_valid), 32'(0));
    nbytes = cycles - 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  int         nb;
  logic [7:0] pb;
  int         rej_before;
  int         done_before;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    addr  = 2'd0;
    len   = 6'd0;
    busy  = 1'b0;
    #12;
    check("rst_datain", 32'(datain), 32'(0));
    check("rst_pv", 32'(packet_valid), 32'(0));
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rej", 32'(rej), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single-byte packet: 05, A5, A0.
    done_before = done_cnt;
    run_packet(2'd1, 6'd1, 0, 0, 0, nb, pb);
    check("p1_hdr", 32'(obs_d[0]), 32'h05);
    check("p1_hdr_pv", 32'(obs_pv[0]), 32'(1));
    check("p1_pay", 32'(obs_d[1]), 32'hA5);
    check("p1_pay_pv", 32'(obs_pv[1]), 32'(1));
    check("p1_par", 32'(obs_d[2]), 32'hA0);
    check("p1_par_pv", 32'(obs_pv[2]), 32'(0));
    check("p1_bytes", 32'(nb), 32'(3));
    check("p1_lfsr_step", 32'(m_lfsr), 32'h4A);
    repeat (2) @(negedge clk);
    #1;
    check("p1_done_once", 32'(done_cnt - done_before), 32'(1));
    @(negedge clk);

    // Back-to-back packets.
    run_packet(2'd0, 6'd16, 0, 0, 0, nb, pb);
    check("b2b_hdr0", 32'(obs_d[0]), 32'h40);
    check("b2b_bytes0", 32'(nb), 32'(18));
    run_packet(2'd1, 6'd14, 0, 0, 0, nb, pb);
    check("b2b_hdr1", 32'(obs_d[0]), 32'h39);
    check("b2b_bytes1", 32'(nb), 32'(16));

    // len=4 from seed, unstalled then stalled: parity 0x42 both times.
    do_reset();
    run_packet(2'd2, 6'd4, 0, 0, 0, nb, pb);
    check("ns_par", 32'(pb), 32'h42);
    check("ns_bytes", 32'(nb), 32'(6));
    do_reset();
    run_packet(2'd2, 6'd4, 3, 3, 0, nb, pb);
    check("st_par", 32'(pb), 32'h42);
    check("st_bytes", 32'(nb), 32'(9));

    // Rejected requests.
    rej_before = rej_cnt;
    start = 1'b1; addr = 2'd3; len = 6'd5;
    @(negedge clk);
    addr = 2'd1; len = 6'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rej_count", 32'(rej_cnt - rej_before), 32'(2));
    check("rej_ready", 32'(ready), 32'(1));

    // Start during a packet is ignored.
    rej_before = rej_cnt;
    run_packet(2'd2, 6'd8, 0, 0, 3, nb, pb);
    check("ign_bytes", 32'(nb), 32'(10));
    #1;
    check("ign_no_rej", 32'(rej_cnt - rej_before), 32'(0));
    @(negedge clk);

    // Reset while payload byte 5 of a len=10 packet is on the bus.
    done_before = done_cnt;
    start = 1'b1; addr = 2'd0; len = 6'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_pv", 32'(packet_valid), 32'(0));
    check("mid_rst_datain", 32'(datain), 32'(0));
    check("mid_rst_ready", 32'(ready), 32'(1));
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("mid_rst_no_done", 32'(done_cnt - done_before), 32'(0));
    @(negedge clk);
    run_packet(2'd0, 6'd1, 0, 0, 0, nb, pb);
    check("post_rst_pay", 32'(obs_d[1]), 32'hA5);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
